// File: rtl/updown_counter_pkg.sv
// ============================================================================
// Module   : updown_counter_pkg
// Brief    : Shared encodings and helpers for the up/down counter family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package updown_counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Bits needed to hold values 0..n-1 (minimum 1).
    function automatic int cnt_clog2(input longint n);
        int r;
        longint v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/updown_counter_mod_addsub.sv
// ============================================================================
// Module   : mod_addsub
// Brief    : Combinational modulo add/subtract with wrap or saturate handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_addsub
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int MODULUS  = 2048,
    parameter int SAT_MODE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt,
    output logic             carry,
    output logic             borrow
);

    localparam logic [WIDTH:0]   c_mod = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   c_max = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_top = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] w_cnt_x;
    logic [WIDTH:0] w_step_x;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_sum_wrap;
    logic [WIDTH:0] w_dif_wrap;

    // One extra bit so nothing truncates before the range compare.
    assign w_cnt_x    = {1'b0, count};
    assign w_step_x   = {1'b0, step};
    assign w_sum      = w_cnt_x + w_step_x;
    assign w_sum_wrap = w_sum - c_mod;
    assign w_dif_wrap = w_cnt_x + c_mod - w_step_x;

    always_comb begin
        nxt    = count;
        carry  = 1'b0;
        borrow = 1'b0;
        if (dir) begin
            if (w_sum <= c_max) begin
                nxt = w_sum[WIDTH-1:0];
            end else begin
                carry = 1'b1;
                nxt   = (SAT_MODE == CNT_SAT) ? c_top : w_sum_wrap[WIDTH-1:0];
            end
        end else begin
            if (w_cnt_x >= w_step_x) begin
                nxt = count - step;
            end else begin
                borrow = 1'b1;
                nxt    = (SAT_MODE == CNT_SAT) ? '0 : w_dif_wrap[WIDTH-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/updown_counter_mod.sv
// ============================================================================
// Module   : updown_counter_mod
// Brief    : Up/down counter with programmable modulus, step, wrap/saturate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_counter_mod
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int MODULUS  = 2048,
    parameter int SAT_MODE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_min,
    output logic             load_err
);

    localparam logic [WIDTH:0]   c_mod = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_top = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("updown_counter_mod: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_carry;
    logic             r_borrow;
    logic             r_at_max;
    logic             r_at_min;
    logic             r_load_err;

    logic [WIDTH-1:0] w_as_cnt;
    logic             w_as_carry;
    logic             w_as_borrow;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_carry_nxt;
    logic             w_borrow_nxt;
    logic             w_lerr_nxt;
    logic             w_load_bad;

    mod_addsub #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SAT_MODE (SAT_MODE)
    ) u_addsub (
        .count  (r_count),
        .step   (step),
        .dir    (dir),
        .nxt    (w_as_cnt),
        .carry  (w_as_carry),
        .borrow (w_as_borrow)
    );

    assign w_load_bad = ({1'b0, load_val} >= c_mod);

    always_comb begin
        w_cnt_nxt    = r_count;
        w_carry_nxt  = 1'b0;
        w_borrow_nxt = 1'b0;
        w_lerr_nxt   = 1'b0;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (load) begin
            w_cnt_nxt  = w_load_bad ? c_top : load_val;
            w_lerr_nxt = w_load_bad;
        end else if (en) begin
            w_cnt_nxt    = w_as_cnt;
            w_carry_nxt  = w_as_carry;
            w_borrow_nxt = w_as_borrow;
        end
    end

    // Range flags are registered from the next count so they track count exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_at_max   <= 1'b0;
            r_at_min   <= 1'b1;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_cnt_nxt;
            r_carry    <= w_carry_nxt;
            r_borrow   <= w_borrow_nxt;
            r_at_max   <= (w_cnt_nxt == c_top);
            r_at_min   <= (w_cnt_nxt == '0);
            r_load_err <= w_lerr_nxt;
        end
    end

    assign count    = r_count;
    assign carry    = r_carry;
    assign borrow   = r_borrow;
    assign at_max   = r_at_max;
    assign at_min   = r_at_min;
    assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
// ============================================================================
// Module   : tb_updown_counter_mod
// Brief    : Directed self-checking bench: modulus-10 wrap/sat and defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_counter_mod;
    import updown_counter_pkg::*;

    localparam int W10 = cnt_clog2(10);

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        load;
    logic [10:0] load_val;
    logic        en;
    logic        dir;
    logic [10:0] step;

    logic [W10-1:0] w_cnt, s_cnt;
    logic           w_cy, w_bw, w_mx, w_mn, w_le;
    logic           s_cy, s_bw, s_mx, s_mn, s_le;
    logic [10:0]    d_cnt;
    logic           d_cy, d_bw, d_mx, d_mn, d_le;

    int total;
    int bad;

    updown_counter_mod #(.WIDTH(W10), .MODULUS(10), .SAT_MODE(CNT_WRAP)) u_wrap10 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[W10-1:0]),
        .en(en), .dir(dir), .step(step[W10-1:0]), .count(w_cnt), .carry(w_cy),
        .borrow(w_bw), .at_max(w_mx), .at_min(w_mn), .load_err(w_le));

    updown_counter_mod #(.WIDTH(W10), .MODULUS(10), .SAT_MODE(CNT_SAT)) u_sat10 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[W10-1:0]),
        .en(en), .dir(dir), .step(step[W10-1:0]), .count(s_cnt), .carry(s_cy),
        .borrow(s_bw), .at_max(s_mx), .at_min(s_mn), .load_err(s_le));

    updown_counter_mod u_def (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .step(step), .count(d_cnt), .carry(d_cy),
        .borrow(d_bw), .at_max(d_mx), .at_min(d_mn), .load_err(d_le));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Steps used here are always legal for the modulus-10 instances.
    always @(posedge clk) begin
        if (rst_n && en && !clr && !load) begin
            assert (step < 11'd10) else $error("illegal step %0d", step);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; step = '0; load_val = '0;
    endtask

    task automatic do_load(input logic [10:0] v);
        idle();
        load = 1'b1; load_val = v;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        total++;
        if (w_cnt !== 4'd0 || w_mn !== 1'b1 || w_mx !== 1'b0 || {w_cy, w_bw, w_le} !== 3'b000) begin
            bad++; $display("FAIL reset_wrap10 cnt=%0d min=%b max=%b pulses=%b%b%b required cnt=0 min=1 max=0 pulses=000",
                            w_cnt, w_mn, w_mx, w_cy, w_bw, w_le);
        end
        total++;
        if (d_cnt !== 11'd0 || d_mn !== 1'b1 || d_mx !== 1'b0 || {d_cy, d_bw, d_le} !== 3'b000) begin
            bad++; $display("FAIL reset_default cnt=%0d min=%b max=%b pulses=%b%b%b required cnt=0 min=1 max=0 pulses=000",
                            d_cnt, d_mn, d_mx, d_cy, d_bw, d_le);
        end
        do_load(11'd7);
        total++;
        if (w_cnt !== 4'd7 || w_mn !== 1'b0) begin
            bad++; $display("FAIL load7 cnt=%0d min=%b required cnt=7 min=0", w_cnt, w_mn);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (w_cnt !== 4'd0 || w_mn !== 1'b1 || d_cnt !== 11'd0) begin
            bad++; $display("FAIL async_reset wrap_cnt=%0d min=%b def_cnt=%0d required 0/1/0", w_cnt, w_mn, d_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_c [4] = '{4'd3, 4'd6, 4'd9, 4'd2};
        logic       exp_y [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_m [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        idle();
        clr = 1'b1;
        tick();
        idle();
        en = 1'b1; dir = 1'b1; step = 11'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (w_cnt !== exp_c[i] || w_cy !== exp_y[i] || w_mx !== exp_m[i] || w_bw !== 1'b0) begin
                bad++; $display("FAIL wrap_up[%0d] cnt=%0d carry=%b max=%b borrow=%b required cnt=%0d carry=%b max=%b borrow=0",
                                i, w_cnt, w_cy, w_mx, w_bw, exp_c[i], exp_y[i], exp_m[i]);
            end
        end
        idle();
    endtask

    task automatic test_wrap_down();
        logic [3:0] exp_c [4] = '{4'd8, 4'd4, 4'd0, 4'd6};
        logic       exp_b [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       exp_n [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_load(11'd2);
        en = 1'b1; dir = 1'b0; step = 11'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (w_cnt !== exp_c[i] || w_bw !== exp_b[i] || w_mn !== exp_n[i] || w_cy !== 1'b0) begin
                bad++; $display("FAIL wrap_down[%0d] cnt=%0d borrow=%b min=%b carry=%b required cnt=%0d borrow=%b min=%b carry=0",
                                i, w_cnt, w_bw, w_mn, w_cy, exp_c[i], exp_b[i], exp_n[i]);
            end
        end
        idle();
    endtask

    task automatic test_saturate();
        logic       v_dir [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] v_stp [4] = '{4'd5, 4'd5, 4'd9, 4'd1};
        logic [3:0] exp_c [4] = '{4'd9, 4'd9, 4'd0, 4'd0};
        logic       exp_y [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_b [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_load(11'd7);
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; dir = v_dir[i]; step = {7'd0, v_stp[i]};
            tick();
            total++;
            if (s_cnt !== exp_c[i] || s_cy !== exp_y[i] || s_bw !== exp_b[i]) begin
                bad++; $display("FAIL sat[%0d] cnt=%0d carry=%b borrow=%b required cnt=%0d carry=%b borrow=%b",
                                i, s_cnt, s_cy, s_bw, exp_c[i], exp_y[i], exp_b[i]);
            end
        end
        idle();
    endtask

    task automatic test_load_err();
        do_load(11'd12);
        total++;
        if (w_cnt !== 4'd9 || w_le !== 1'b1 || w_mx !== 1'b1) begin
            bad++; $display("FAIL load_err cnt=%0d err=%b max=%b required cnt=9 err=1 max=1", w_cnt, w_le, w_mx);
        end
        tick();
        total++;
        if (w_cnt !== 4'd9 || w_le !== 1'b0) begin
            bad++; $display("FAIL load_err_pulse cnt=%0d err=%b required cnt=9 err=0", w_cnt, w_le);
        end
        clr = 1'b1; load = 1'b1; load_val = 11'd12; en = 1'b1; dir = 1'b1; step = 11'd3;
        tick();
        idle();
        total++;
        if (w_cnt !== 4'd0 || {w_cy, w_bw, w_le} !== 3'b000 || w_mn !== 1'b1) begin
            bad++; $display("FAIL clr_priority cnt=%0d pulses=%b%b%b min=%b required cnt=0 pulses=000 min=1",
                            w_cnt, w_cy, w_bw, w_le, w_mn);
        end
    endtask

    task automatic test_default();
        do_load(11'd2047);
        total++;
        if (d_cnt !== 11'd2047 || d_mx !== 1'b1 || d_le !== 1'b0) begin
            bad++; $display("FAIL def_load cnt=%0d max=%b err=%b required cnt=2047 max=1 err=0", d_cnt, d_mx, d_le);
        end
        en = 1'b1; dir = 1'b1; step = 11'd1;
        tick();
        total++;
        if (d_cnt !== 11'd0 || d_cy !== 1'b1 || d_mn !== 1'b1) begin
            bad++; $display("FAIL def_up_wrap cnt=%0d carry=%b min=%b required cnt=0 carry=1 min=1", d_cnt, d_cy, d_mn);
        end
        dir = 1'b0;
        tick();
        total++;
        if (d_cnt !== 11'd2047 || d_bw !== 1'b1 || d_cy !== 1'b0) begin
            bad++; $display("FAIL def_down_wrap cnt=%0d borrow=%b carry=%b required cnt=2047 borrow=1 carry=0", d_cnt, d_bw, d_cy);
        end
        dir = 1'b1; step = 11'd0;
        tick();
        total++;
        if (d_cnt !== 11'd2047 || {d_cy, d_bw, d_le} !== 3'b000 || d_mx !== 1'b1) begin
            bad++; $display("FAIL def_step0 cnt=%0d pulses=%b%b%b max=%b required cnt=2047 pulses=000 max=1",
                            d_cnt, d_cy, d_bw, d_le, d_mx);
        end
        idle();
        tick();
        total++;
        if (d_cnt !== 11'd2047 || {d_cy, d_bw, d_le} !== 3'b000) begin
            bad++; $display("FAIL def_hold cnt=%0d pulses=%b%b%b required cnt=2047 pulses=000", d_cnt, d_cy, d_bw, d_le);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        idle();
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load_err();
        test_default();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
